// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the 32-bit ripple-carry ALU
// Purpose : operation encodings for {sel1,sel0} and the default datapath width.
// Ports   : none (package).
package alu_pkg;

   localparam int WIDTH = 32;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

endpackage

// File: rtl/alu_1bit.sv
// rtl/alu_1bit.sv - one combinational bit slice of the ripple-carry ALU
// Purpose : AND / OR / full-add / pass-through of 'less' for a single bit.
// Ports   : a, b     operand bits
//           cin      carry in from the next lower slice
//           binv     invert b before use (all ops)
//           less     bit routed to res for OP_SLT
//           op[1:0]  operation select
//           res      slice result
//           cout     carry out to the next higher slice
module alu_1bit
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       binv,
   input  logic       less,
   input  logic [1:0] op,
   output logic       res,
   output logic       cout
);

   logic bb;
   logic sum;

   assign bb   = b ^ binv;
   assign sum  = a ^ bb ^ cin;
   // Carry is produced in every mode so co tracks the adder regardless of op.
   assign cout = (a & bb) | (a & cin) | (bb & cin);

   always_comb begin
      res = 1'b0;
      case (op)
         OP_AND:  res = a & bb;
         OP_OR:   res = a | bb;
         OP_ADD:  res = sum;
         default: res = less;
      endcase
   end

endmodule

// File: rtl/alu_32bit.sv
// rtl/alu_32bit.sv - registered 32-bit ALU built from a chain of 1-bit slices
// Purpose : AND, OR, ADD/SUB (binv + cin) and set-less-than, one-cycle latency.
// Option  : ALU_INTERNAL_SLT_EN - when defined, OP_SLT yields the signed
//           a < bb flag in bit 0 instead of passing 'less' through.
// Ports   : clk       rising-edge clock
//           rst_n     synchronous active-low reset
//           a, b      operands
//           cin       carry into bit 0
//           binv      use ~b instead of b
//           less      value routed to result for OP_SLT (option undefined)
//           sel1/sel0 operation select {sel1,sel0}
//           result    registered result
//           co        registered carry out of the MSB
module alu_32bit
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             binv,
   input  logic [WIDTH-1:0] less,
   input  logic             sel1,
   input  logic             sel0,
   output logic [WIDTH-1:0] result,
   output logic             co
);

   logic [1:0]       op;
   logic [WIDTH-1:0] slt_in;
   logic [WIDTH-1:0] res_c;
   logic             carry_msb;

   assign op = {sel1, sel0};

   // Each slice owns its carry signals so the ripple is a chain of distinct
   // nets rather than feedback through one vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      logic c_in;
      logic c_out;

      if (i == 0) begin : g_first
         assign c_in = cin;
      end else begin : g_rest
         assign c_in = g_slice[i-1].c_out;
      end

      alu_1bit u_bit (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c_in),
         .binv (binv),
         .less (slt_in[i]),
         .op   (op),
         .res  (res_c[i]),
         .cout (c_out)
      );
   end

   assign carry_msb = g_slice[WIDTH-1].c_out;

`ifdef ALU_INTERNAL_SLT_EN
   // sum[msb] ^ overflow: sum[msb] = a^bb^c_in(msb) and overflow =
   // c_in(msb)^c_out(msb), so the carry into the MSB cancels out.
   logic set_bit;
   assign set_bit = a[WIDTH-1] ^ b[WIDTH-1] ^ binv ^ carry_msb;
   assign slt_in  = {{(WIDTH-1){1'b0}}, set_bit};
`else
   assign slt_in  = less;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= '0;
         co     <= 1'b0;
      end else begin
         result <= res_c;
         co     <= carry_msb;
      end
   end

endmodule

// File: tb/tb_alu_32bit.sv
// tb/tb_alu_32bit.sv - self-checking bench for alu_32bit
module tb_alu_32bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a, b, less;
   logic        cin, binv, sel1, sel0;
   logic [31:0] result;
   logic        co;

   int n_checks = 0;
   int n_pass   = 0;

   alu_32bit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .binv   (binv),
      .less   (less),
      .sel1   (sel1),
      .sel0   (sel0),
      .result (result),
      .co     (co)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference: arithmetic on wide integers, signed compare done numerically.
   function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mcin, input logic mbinv,
                                 input logic [31:0] mless, input logic [1:0] mop,
                                 output logic [31:0] r, output logic c);
      logic [31:0] bb;
      logic [32:0] s;
      longint      ss;
      bb = mbinv ? ~mb : mb;
      s  = {1'b0, ma} + {1'b0, bb} + {32'd0, mcin};
      ss = longint'($signed(ma)) + longint'($signed(bb)) + longint'(mcin);
      case (mop)
         2'b00:   r = ma & bb;
         2'b01:   r = ma | bb;
         2'b10:   r = s[31:0];
`ifdef ALU_INTERNAL_SLT_EN
         default: r = (ss < 0) ? 32'd1 : 32'd0;
`else
         default: r = mless;
`endif
      endcase
      c = s[32];
   endfunction

   task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                        input logic tbinv, input logic [31:0] tless, input logic [1:0] top);
      a = ta; b = tb; cin = tcin; binv = tbinv; less = tless; {sel1, sel0} = top;
      @(posedge clk);
      #1;
   endtask

   task automatic run_exp(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic tbinv, input logic [31:0] tless,
                          input logic [1:0] top, input logic [31:0] er, input logic ec);
      drive(ta, tb, tcin, tbinv, tless, top);
      check({tag, "_res"}, result, er);
      check({tag, "_co"}, {31'd0, co}, {31'd0, ec});
   endtask

   initial begin
      logic [31:0] er, ra, rb, rl;
      logic        ec;
      logic [31:0] corners [6];
      corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h8000_0000;
      corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h0000_0001; corners[5] = 32'hAAAA_AAAA;

      rst_n = 1'b0;
      a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; binv = 1'b0; less = 32'hFFFF_FFFF;
      {sel1, sel0} = 2'b10;
      repeat (2) @(posedge clk);
      #1;
      check("reset_res", result, 32'd0);
      check("reset_co", {31'd0, co}, 32'd0);
      rst_n = 1'b1;

      run_exp("add_1_3",   32'h1, 32'h3, 1'b0, 1'b0, 32'd0, 2'b10, 32'h4, 1'b0);
      run_exp("and_alt",   32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'd0, 2'b00, 32'h0, 1'b0);
      run_exp("or_alt",    32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'd0, 2'b01, 32'hFFFF_FFFF, 1'b0);
      run_exp("add_wrap",  32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'd0, 2'b10, 32'h0, 1'b1);
      run_exp("add_ones",  32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'd0, 2'b10, 32'hFFFF_FFFF, 1'b0);
      run_exp("binv_add",  32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b1, 32'd0, 2'b10, 32'hAAAA_AAAA, 1'b0);
      run_exp("sub_10_1",  32'h10, 32'h1, 1'b1, 1'b1, 32'd0, 2'b10, 32'hF, 1'b1);
      run_exp("wrap_max",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'd0, 2'b10, 32'h0, 1'b1);
`ifdef ALU_INTERNAL_SLT_EN
      run_exp("slt_1_2",   32'h1, 32'h2, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b11, 32'h1, 1'b0);
      run_exp("slt_neg",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'd0, 2'b11, 32'h1, 1'b1);
      run_exp("slt_ge",    32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 2'b11, 32'h0, 1'b0);
`else
      run_exp("slt_less0", 32'h1, 32'h2, 1'b1, 1'b1, 32'd0, 2'b11, 32'h0, 1'b0);
      run_exp("slt_pass",  32'h1, 32'h2, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b11, 32'hDEAD_BEEF, 1'b0);
`endif

      // Reset held while a nonzero op is presented, then released.
      rst_n = 1'b0;
      run_exp("rst_mid",   32'h5, 32'h3, 1'b0, 1'b0, 32'd0, 2'b10, 32'h0, 1'b0);
      rst_n = 1'b1;
      run_exp("rst_rel",   32'h5, 32'h3, 1'b0, 1'b0, 32'd0, 2'b10, 32'h8, 1'b0);
      rst_n = 1'b0;
      run_exp("rst_or",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 2'b01, 32'h0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         ra = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
         rb = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
         rl = $urandom;
         drive(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), rl, 2'($urandom_range(3)));
         model(a, b, cin, binv, less, {sel1, sel0}, er, ec);
         check("rand_res", result, er);
         check("rand_co", {31'd0, co}, {31'd0, ec});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
